// File: rtl/vga_char_loader.sv
// ---------------------------------------------------------------------------
// vga_char_loader
//
// Purpose:
//   Walks the word-addressed VGA data ROM from a base address and streams one
//   character per 32-bit word to the text-buffer writer over a valid/ready
//   handshake. Each character comes from the low byte of its word. When the
//   run is started with decrypt set, the character is the bitwise NOT of
//   that byte. The run ends after the requested number of characters or when
//   a NUL character appears, whichever happens first.
//
// Ports:
//   i_clk            system clock, rising edge
//   i_reset          synchronous active-high reset
//   i_start          one-cycle run command, only honoured while idle
//   i_base_addr      first ROM byte address (bits [1:0] ignored)
//   i_char_count     maximum characters for this run
//   i_decrypt        invert each character byte when set (latched at start)
//   o_mem_addr       registered ROM byte address
//   i_mem_data       ROM word for o_mem_addr, valid in the same cycle
//   o_char_valid     o_char_code / o_char_index are valid
//   i_char_ready     downstream accepts when valid and ready are both high
//   o_char_code      decoded character
//   o_char_index     cell index of the character, wraps modulo 2^IDX_W
//   o_busy           high whenever a run is in progress
//   o_done           one-cycle pulse at the end of a run
//   o_chars_emitted  characters accepted in the last/current run
// ---------------------------------------------------------------------------
module vga_char_loader #(
  parameter int ADDR_W = 11,
  parameter int CNT_W  = 7,
  parameter int IDX_W  = 6
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [CNT_W-1:0]  i_char_count,
  input  logic              i_decrypt,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic [31:0]       i_mem_data,
  output logic              o_char_valid,
  input  logic              i_char_ready,
  output logic [7:0]        o_char_code,
  output logic [IDX_W-1:0]  o_char_index,
  output logic              o_busy,
  output logic              o_done,
  output logic [CNT_W-1:0]  o_chars_emitted
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_EMIT,
    S_FINISH
  } state_t;

  state_t             r_state;
  state_t             w_next_state;

  logic [ADDR_W-1:0]  r_mem_addr;
  logic [7:0]         r_char_code;
  logic [IDX_W-1:0]   r_char_index;
  logic [CNT_W-1:0]   r_chars_emitted;
  logic [CNT_W-1:0]   r_count;
  logic               r_decrypt;

  logic [7:0]         w_decoded;
  logic               w_handshake;
  logic [CNT_W-1:0]   w_emitted_next;
  logic               w_unused;

  // The upper ROM bytes and the low base-address bits never affect the
  // character stream. They are folded into one marker signal so that it is
  // obvious they are ignored on purpose.
  assign w_unused = &{1'b0, i_mem_data[31:8], i_base_addr[1:0]};

  // Decoding looks only at the current ROM word and the decrypt flag latched
  // at start. That way, changing i_decrypt mid-run cannot corrupt a string.
  // A handshake is counted only while a character is actually being offered.
  assign w_decoded      = r_decrypt ? ~i_mem_data[7:0] : i_mem_data[7:0];
  assign w_handshake    = (r_state == S_EMIT) && i_char_ready;
  assign w_emitted_next = r_chars_emitted + CNT_W'(1);

  // State register. Reset wins over everything, even in the middle of a run,
  // so the sequencer always comes back to a quiet idle state.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic. FETCH always takes exactly one cycle, because the ROM
  // answers combinationally. EMIT waits for the consumer for as long as
  // needed. A zero count skips fetching entirely and only pulses done. A NUL
  // character ends the run without being offered downstream.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          if (i_char_count == '0) begin
            w_next_state = S_FINISH;
          end else begin
            w_next_state = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        if (w_decoded == 8'h00) begin
          w_next_state = S_FINISH;
        end else begin
          w_next_state = S_EMIT;
        end
      end
      S_EMIT: begin
        if (w_handshake) begin
          if (w_emitted_next == r_count) begin
            w_next_state = S_FINISH;
          end else begin
            w_next_state = S_FETCH;
          end
        end
      end
      S_FINISH: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Datapath registers.
  // At start, the run parameters are captured so that the inputs are free to
  // change afterwards. The character is captured in FETCH and then held in
  // EMIT, which keeps code and index stable under backpressure. Address,
  // index and count only advance on an accepted character. The address wraps
  // naturally at the top of the ROM.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_mem_addr      <= '0;
      r_char_code     <= '0;
      r_char_index    <= '0;
      r_chars_emitted <= '0;
      r_count         <= '0;
      r_decrypt       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_mem_addr      <= {i_base_addr[ADDR_W-1:2], 2'b00};
            r_count         <= i_char_count;
            r_decrypt       <= i_decrypt;
            r_char_index    <= '0;
            r_chars_emitted <= '0;
          end
        end
        S_FETCH: begin
          if (w_decoded != 8'h00) begin
            r_char_code <= w_decoded;
          end
        end
        S_EMIT: begin
          if (w_handshake) begin
            r_chars_emitted <= w_emitted_next;
            r_char_index    <= r_char_index + IDX_W'(1);
            r_mem_addr      <= r_mem_addr + ADDR_W'(4);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Status outputs are decoded straight from the registered state, so they
  // change only on clock edges. In particular, valid drops in the cycle after
  // a handshake because the state has already left EMIT by then.
  assign o_mem_addr      = r_mem_addr;
  assign o_char_code     = r_char_code;
  assign o_char_index    = r_char_index;
  assign o_chars_emitted = r_chars_emitted;
  assign o_char_valid    = (r_state == S_EMIT);
  assign o_busy          = (r_state != S_IDLE);
  assign o_done          = (r_state == S_FINISH);

endmodule

// File: doc/vga_char_loader.md
Name: vga_char_loader

Overview:
Sequencer that walks the 32-bit word-addressed VGA data ROM and streams one character per word to the VGA text-buffer writer. On a start command it reads the ROM from a base address at a stride of 4 bytes, optionally decrypts each character by bitwise NOT, and hands it off over a valid/ready handshake. It stops early on a NUL terminator and reports completion. It sits between the VGA data ROM (combinational read) and the character-cell writer.

Parameters:
ADDR_W, 11, ROM byte-address width; stride fixed at 4.
CNT_W, 7, width of char_count / chars_emitted; maximum 127 characters per run.
IDX_W, 6, width of char_index (cell position); wraps modulo 2^IDX_W.

Ports:
clk  in  1  system clock; all state changes on rising edge.
reset  in  1  synchronous, active-high reset.
start  in  1  one-cycle command; sampled only in IDLE.
base_addr  in  ADDR_W  first ROM byte address; bits [1:0] ignored (treated as 0).
char_count  in  CNT_W  maximum characters to emit this run.
decrypt  in  1  1: char = ~mem_data[7:0]; 0: char = mem_data[7:0]. Latched at start.
mem_addr  out  ADDR_W  ROM address, registered.
mem_data  in  32  ROM data; valid combinationally in the same cycle as mem_addr.
char_valid  out  1  char_code/char_index valid.
char_ready  in  1  downstream accepts when char_valid & char_ready.
char_code  out  8  decoded ASCII character.
char_index  out  IDX_W  cell index of the character (0 for the first char of a run).
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse at end of run.
chars_emitted  out  CNT_W  accepted characters in the last/current run; held until the next start.

Behaviour:
- Reset (synchronous, takes priority over everything including mid-run): state=IDLE; mem_addr=0, char_valid=0, char_code=0, char_index=0, busy=0, done=0, chars_emitted=0.
- States: IDLE, FETCH, EMIT, FINISH.
- IDLE: start=1 -> latch base_addr & ~3 into mem_addr, latch char_count and decrypt, clear char_index and chars_emitted. If char_count==0 -> FINISH, else -> FETCH.
- FETCH (1 cycle): decode mem_data[7:0] per the latched decrypt. If the decoded value is 0x00 -> FINISH (terminator, not emitted). Otherwise register it into char_code -> EMIT.
- EMIT: char_valid=1. char_code/char_index are held stable until accepted. On handshake: chars_emitted+1, char_index+1, mem_addr+4 (wraps modulo 2^ADDR_W). If the new chars_emitted equals the latched count -> FINISH, else -> FETCH. Without ready, stay in EMIT indefinitely.
- FINISH: done=1 for exactly this cycle, busy=1 -> IDLE.
- Latency: start at edge N -> FETCH from N+1 -> first char_valid at N+2. Each character needs at least 2 cycles (FETCH+EMIT), so maximum throughput is 1 character per 2 cycles.
- start is ignored while busy. Inputs base_addr, char_count and decrypt may change after start without effect.
- mem_addr wrap: 0x7FC+4 -> 0x000, and the run continues.
- char_index wraps modulo 2^IDX_W independently of chars_emitted.
- char_valid never asserts in FETCH, FINISH or IDLE. char_valid drops in the cycle after the handshake.

Test Plan:
- Plain string: base_addr=0x000, count=4, decrypt=0, ready=1 -> chars 0x48,0x4F,0x4C,0x41 at index 0..3; mem_addr 0x000,0x004,0x008,0x00C; done one cycle after the last accept; chars_emitted=4; first valid 2 cycles after start.
- Decrypt: base_addr=0x012 (low bits dropped to 0x010), count=4, decrypt=1 -> 0x4F,0x4C,0x41,0x26 ('O','L','A','&'); chars_emitted=4.
- Terminator: base_addr=0x01C, count=10, decrypt=0 -> single char 0xD9 at index 0, then word 0x020=0 ends the run; done pulse; chars_emitted=1; no valid for the zero word.
- Backpressure: the plain-string run with char_ready low for 5 cycles on char 2 -> char_code=0x4C and index 2 held stable for all stall cycles; exactly 4 handshakes total; no duplicates.
- Edge commands: count=0 -> done 1 cycle after start, no char_valid, chars_emitted=0. A second start while busy is ignored. base_addr=0x7FC, count=2 -> mem_addr sequence 0x7FC then 0x000.
- Reset mid-run: assert reset while in EMIT on char 1 -> next edge all outputs are 0 and state is IDLE; a new start then runs cleanly from index 0.
